lw_sha_schedule_ctrl: RTL
=========================

# lw_sha_schedule_ctrl

Message-schedule controller for the lightweight SHA core. It owns the 16-word circular W buffer and loads one 512/1024-bit block word by word. It then sequences the `lw_sha_expansion` datapath to stream W_0..W_{N-1} to the compression round logic over a valid/ready handshake. N is 64 for SHA-256 and 80 for SHA-512. It sits between the block-input interface and the round engine.

## Interface
- No parameters. Word width is `` `WORD_SIZE ``, and the architecture is selected by `CORE_ARCH_S32` / `CORE_ARCH_S64` from `defines.v`.
- `clk` input 1: single clock.
- `rst` input 1: synchronous, active-high reset.
- `mode` input 1: present only under `CORE_ARCH_S64`. 1 selects SHA-512 (N=80); 0 selects SHA-256 (N=64). Sampled on an accepted `start`.
- `start` input 1: begin a block. Accepted only in IDLE.
- `msg_valid` input 1: input word valid.
- `msg_word` input `` `WORD_SIZE ``: message word, big-endian order, W_0 first.
- `msg_ready` output 1: controller accepts `msg_word`.
- `wt_valid` output 1: `wt` holds W_t for `round_idx`.
- `wt_ready` input 1: round engine consumes W_t.
- `wt` output `` `WORD_SIZE ``: current schedule word. Forced to 0 when `wt_valid`=0.
- `round_idx` output 7: current t (0..N-1). 0 outside STREAM.
- `last_round` output 1: `wt_valid` && t==N-1.
- `busy` output 1: state != IDLE.
- `done` output 1: one-cycle pulse after W_{N-1} is consumed.

## Operation
- States:
  - IDLE: `msg_ready`=0, `wt_valid`=0. `start` moves to LOAD, clears the load counter, and latches `mode` into `mode_q`.
  - LOAD: `msg_ready`=1. On `msg_valid`&&`msg_ready`, write `w[cnt]`=`msg_word` and increment `cnt`. Acceptance of word 15 moves to STREAM with t=0.
  - STREAM: `wt_valid`=1.
    - t<16: `wt`=`w[t]`.
    - t≥16: `wt`=`expanded_word` from `lw_sha_expansion`, with `round_index`=t[3:0] and mode=`mode_q`.
    - On handshake with t≥16: write `w[t[3:0]]`=`expanded_word`.
    - On any handshake: t increments.
    - Handshake at t==N-1 moves to IDLE and asserts `done` in the following cycle.
- `start` outside IDLE is ignored. `msg_valid` outside LOAD is ignored; no write occurs.
- There is no abort input. Only `rst` terminates a block.
- Circular-buffer invariant: entering round t≥16, `w[t mod 16]` holds W_{t-16}, `w[(t-15) mod 16]`=W_{t-15}, `w[(t-7) mod 16]`=W_{t-7`}, `w[(t-2) mod 16]`=W_{t-2}.
- Arithmetic is modulo 2^`WORD_SIZE` and is done inside the expansion unit. The controller performs no width extension.
- Under `CORE_ARCH_S32`, N is fixed at 64 and `mode_q` does not exist.

## Timing
- Reset values:
  - state=IDLE, `cnt`=0, t=0, `mode_q`=0.
  - All outputs 0: `msg_ready`, `wt_valid`, `wt`, `round_idx`, `last_round`, `busy`, `done`.
  - W buffer contents are not reset and are don't-care.
- `start` at cycle c gives `msg_ready`=1 at c+1.
- Word 15 accepted at cycle c gives `wt_valid`=1 with t=0 at c+1.
- With `wt_ready` held high, one W_t is produced per cycle. Minimum block time is 1+16+N cycles from `start` to the final handshake.
- `wt` is combinational from the buffer and `mode_q`. It must stay stable while `wt_valid`&&!`wt_ready`. Buffer writes happen only on a handshake.
- `done` rises the cycle after the final handshake, coincident with IDLE. A `start` in that same cycle is accepted, so back-to-back blocks are allowed.
- `rst` asserted in any state gives IDLE on the next edge. Partial data is discarded, and no `done` is produced.
- `msg_valid` low during LOAD stalls `cnt`. `wt_ready` low stalls t. There is no timeout.

## Structure
- Shared package `lw_sha_pkg` holds:
  - the state enum `sched_state_t` (IDLE, LOAD, STREAM);
  - constants `SHA256_ROUNDS`=64, `SHA512_ROUNDS`=80, `SCHED_DEPTH`=16.
- One sub-module: `lw_sha_expansion`, instantiated once. The controller passes `w[15:0]`, t[3:0], and `mode_q` under `CORE_ARCH_S64`.
- Buffer: 16 × `` `WORD_SIZE `` flops with a single write port, addressed by `cnt` in LOAD and t[3:0] in STREAM.

## Test plan
- SHA-256 "abc" padded block (`msg_word`s 0x61626380, 0×14, 0x00000018), `wt_ready`=1:
  - W_16=0x61626380, W_17=0x000F0000, W_18=0x7DA86405.
  - All 64 words match the golden model.
  - `last_round` only at t=63; `done` one cycle later; 81 cycles from `start` to the final handshake.
- All-zero block: every W_t=0. `wt`=0 whenever `wt_valid`=0.
- Random `msg_valid` / `wt_ready` gaps (≈50%): sequence identical to the no-stall run; `wt` stable during each stall.
- `CORE_ARCH_S64`, `mode`=1, SHA-512 "abc" block: 80 words match the golden model. `mode` toggled mid-block has no effect.
- `start` pulsed during LOAD and STREAM is ignored. Back-to-back `start` in the `done` cycle loads the next block correctly.
- `rst` asserted at t=40 returns to IDLE with outputs 0 and no `done`. The next block then produces correct W_t values.

Source files
------------

// File: rtl/lw_sha_pkg.sv
// Shared types, constants and sigma helpers for the lightweight SHA message schedule.

`ifndef WORD_SIZE
   `ifdef CORE_ARCH_S64
      `define WORD_SIZE 64
   `else
      `define WORD_SIZE 32
   `endif
`endif

package lw_sha_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      STREAM = 2'd2
   } sched_state_t;

   localparam int unsigned SHA256_ROUNDS = 64;
   localparam int unsigned SHA512_ROUNDS = 80;
   localparam int unsigned SCHED_DEPTH   = 16;

   // SHA-256 small sigma functions
   function automatic logic [31:0] sig0_256(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
   endfunction

   function automatic logic [31:0] sig1_256(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
   endfunction

   // SHA-512 small sigma functions
   function automatic logic [63:0] sig0_512(input logic [63:0] x);
      return {x[0], x[63:1]} ^ {x[7:0], x[63:8]} ^ (x >> 7);
   endfunction

   function automatic logic [63:0] sig1_512(input logic [63:0] x);
      return {x[18:0], x[63:19]} ^ {x[60:0], x[63:61]} ^ (x >> 6);
   endfunction

endpackage

// File: rtl/lw_sha_expansion.sv
// Message expansion datapath: W_t from the circular 16-word buffer at slot t mod 16.

`ifndef WORD_SIZE
   `ifdef CORE_ARCH_S64
      `define WORD_SIZE 64
   `else
      `define WORD_SIZE 32
   `endif
`endif

module lw_sha_expansion
   import lw_sha_pkg::*;
(
   input  logic [SCHED_DEPTH-1:0][`WORD_SIZE-1:0] i_w,
   input  logic [3:0]                             i_round_index,
`ifdef CORE_ARCH_S64
   input  logic                                   i_mode,
`endif
   output logic [`WORD_SIZE-1:0]                  o_expanded_word
);

   // Slot offsets: t-16 == t, t-15 == t+1, t-7 == t+9, t-2 == t+14 (mod 16)
   logic [3:0]            w_i16, w_i15, w_i7, w_i2;
   logic [`WORD_SIZE-1:0] w_m16, w_m15, w_m7, w_m2;
   logic [31:0]           w_sum32;

   assign w_i16 = i_round_index;
   assign w_i15 = i_round_index + 4'd1;
   assign w_i7  = i_round_index + 4'd9;
   assign w_i2  = i_round_index + 4'd14;

   assign w_m16 = i_w[w_i16];
   assign w_m15 = i_w[w_i15];
   assign w_m7  = i_w[w_i7];
   assign w_m2  = i_w[w_i2];

   // SHA-256 path always works on the low 32 bits
   assign w_sum32 = sig1_256(w_m2[31:0]) + w_m7[31:0] + sig0_256(w_m15[31:0]) + w_m16[31:0];

`ifdef CORE_ARCH_S64
   logic [63:0] w_sum64;
   assign w_sum64 = sig1_512(w_m2) + w_m7 + sig0_512(w_m15) + w_m16;
   assign o_expanded_word = i_mode ? w_sum64 : {32'h0, w_sum32};
`else
   assign o_expanded_word = w_sum32;
`endif

endmodule

// File: rtl/lw_sha_schedule_ctrl.sv
// Message-schedule controller: loads a block into the W buffer, then streams W_0..W_{N-1}.

`ifndef WORD_SIZE
   `ifdef CORE_ARCH_S64
      `define WORD_SIZE 64
   `else
      `define WORD_SIZE 32
   `endif
`endif

module lw_sha_schedule_ctrl
   import lw_sha_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
`ifdef CORE_ARCH_S64
   input  logic                  mode,
`endif
   input  logic                  start,
   input  logic                  msg_valid,
   input  logic [`WORD_SIZE-1:0] msg_word,
   output logic                  msg_ready,
   output logic                  wt_valid,
   input  logic                  wt_ready,
   output logic [`WORD_SIZE-1:0] wt,
   output logic [6:0]            round_idx,
   output logic                  last_round,
   output logic                  busy,
   output logic                  done
);

   sched_state_t r_state, w_state_d;
   logic [3:0]   r_cnt, w_cnt_d;
   logic [6:0]   r_t, w_t_d;
   logic         r_done, w_done_d;
   logic [6:0]   w_last_t;

   logic [SCHED_DEPTH-1:0][`WORD_SIZE-1:0] r_w;
   logic                                   w_we;
   logic [3:0]                             w_waddr;
   logic [`WORD_SIZE-1:0]                  w_wdata;
   logic [`WORD_SIZE-1:0]                  w_expanded;

`ifdef CORE_ARCH_S64
   logic r_mode, w_mode_d;
   assign w_last_t = r_mode ? 7'(SHA512_ROUNDS - 1) : 7'(SHA256_ROUNDS - 1);
`else
   assign w_last_t = 7'(SHA256_ROUNDS - 1);
`endif

   lw_sha_expansion u_expansion (
      .i_w             (r_w),
      .i_round_index   (r_t[3:0]),
`ifdef CORE_ARCH_S64
      .i_mode          (r_mode),
`endif
      .o_expanded_word (w_expanded)
   );

   assign busy = (r_state != IDLE);
   assign done = r_done;

   // Next-state, buffer write port and handshake outputs
   always_comb begin
      w_state_d  = r_state;
      w_cnt_d    = r_cnt;
      w_t_d      = r_t;
      w_done_d   = 1'b0;
`ifdef CORE_ARCH_S64
      w_mode_d   = r_mode;
`endif
      w_we       = 1'b0;
      w_waddr    = r_cnt;
      w_wdata    = msg_word;
      msg_ready  = 1'b0;
      wt_valid   = 1'b0;
      wt         = '0;
      round_idx  = '0;
      last_round = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (start) begin
               w_state_d = LOAD;
               w_cnt_d   = '0;
`ifdef CORE_ARCH_S64
               w_mode_d  = mode;
`endif
            end
         end
         LOAD: begin
            msg_ready = 1'b1;
            if (msg_valid) begin
               w_we    = 1'b1;
               w_cnt_d = r_cnt + 4'd1;
               if (r_cnt == 4'(SCHED_DEPTH - 1)) begin
                  w_state_d = STREAM;
                  w_t_d     = '0;
               end
            end
         end
         STREAM: begin
            wt_valid   = 1'b1;
            round_idx  = r_t;
            wt         = (r_t < 7'(SCHED_DEPTH)) ? r_w[r_t[3:0]] : w_expanded;
            last_round = (r_t == w_last_t);
            if (wt_ready) begin
               w_t_d = r_t + 7'd1;
               // Overwrite W_{t-16}, which no later round needs
               if (r_t >= 7'(SCHED_DEPTH)) begin
                  w_we    = 1'b1;
                  w_waddr = r_t[3:0];
                  w_wdata = w_expanded;
               end
               if (r_t == w_last_t) begin
                  w_state_d = IDLE;
                  w_t_d     = '0;
                  w_done_d  = 1'b1;
               end
            end
         end
         default: w_state_d = IDLE;
      endcase
   end

   // Control registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_t     <= '0;
         r_done  <= 1'b0;
`ifdef CORE_ARCH_S64
         r_mode  <= 1'b0;
`endif
      end else begin
         r_state <= w_state_d;
         r_cnt   <= w_cnt_d;
         r_t     <= w_t_d;
         r_done  <= w_done_d;
`ifdef CORE_ARCH_S64
         r_mode  <= w_mode_d;
`endif
      end
   end

   // W buffer: single write port, contents not reset
   always_ff @(posedge clk) begin
      if (w_we && !rst) begin
         r_w[w_waddr] <= w_wdata;
      end
   end

endmodule
